mdu_ctrl: RTL and testbench

//  Sequencer for the HI/LO multiply/divide unit in the EX stage. Takes MULT/MULTU/DIV/DIVU

---
 rtl/mdu_ctrl_pkg.sv | 14 +
 rtl/mdu_ctrl_div_step.sv | 17 +
 rtl/mdu_ctrl.sv | 95 +++++++++
 tb/tb_mdu_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: op codes, FSM states and helpers for the HI/LO multiply/divide sequencer
package mdu_ctrl_pkg;
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} mdu_state_e;
  localparam int MDU_DIV_STEPS = 32;
  function automatic logic [31:0] mag(input logic neg, input logic [31:0] x);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/mdu_ctrl_div_step.sv
// mdu_ctrl_div_step: one radix-2 restoring divide iteration on unsigned magnitudes
module mdu_ctrl_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);
  logic [32:0] sh;
  logic [31:0] diff;
  logic ge;
  assign sh = {rem, quo[31]};
  assign ge = sh >= {1'b0, dvs};
  assign diff = sh[31:0] - dvs;
  assign rem_n = ge ? diff : sh[31:0];
  assign quo_n = {quo[30:0], ge};
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide sequencer with pipeline stall, flush and hold handling
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_STEPS   = MDU_DIV_STEPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        ex_hold_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);
  mdu_state_e state, state_n;
  mdu_op_e op;
  logic [31:0] a, b, rem, quo, rem_n, quo_n, dvs, q_fix, r_fix;
  logic [5:0] cnt;
  logic signed [63:0] ea, eb;
  logic [63:0] prod, res_n;
  logic launch, sgn_div, a_neg, b_neg, dz_n;
  assign launch = state == S_IDLE && start_i && !flush_i;
  assign sgn_div = op == MDU_DIV;
  assign a_neg = sgn_div & a[31];
  assign b_neg = sgn_div & b[31];
  assign dvs = mag(b_neg, b);
  assign ea = op == MDU_MULT ? {{32{a[31]}}, a} : {32'b0, a};
  assign eb = op == MDU_MULT ? {{32{b[31]}}, b} : {32'b0, b};
  assign prod = ea * eb;
  assign q_fix = mag(a_neg ^ b_neg, quo);
  assign r_fix = mag(a_neg, rem);
  // The only IDLE->DONE path is a divide by zero
  assign res_n = state == S_IDLE ? {src_a_i, 32'hFFFF_FFFF} : state == S_SIGN ? {r_fix, q_fix} : prod;
  assign dz_n = state == S_IDLE ? 1'b1 : state == S_SIGN ? 1'b0 : div_zero_o;
  assign stall_o = !flush_i && ((state == S_IDLE && start_i) || state == S_MUL || state == S_DIV || state == S_SIGN);
  assign done_o = state == S_DONE;
  mdu_ctrl_div_step u_step (
    .rem  (rem),
    .quo  (quo),
    .dvs  (dvs),
    .rem_n(rem_n),
    .quo_n(quo_n)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start_i) state_n = !op_i[1] ? S_MUL : src_b_i == '0 ? S_DONE : S_DIV;
      S_MUL: if (cnt == 6'(MUL_LATENCY - 1)) state_n = S_DONE;
      S_DIV: if (cnt == 6'(DIV_STEPS - 1)) state_n = S_SIGN;
      S_SIGN: state_n = S_DONE;
      S_DONE: if (!ex_hold_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush_i) state_n = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op <= MDU_MULT;
      a <= '0;
      b <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      hi_o <= '0;
      lo_o <= '0;
      div_zero_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == S_MUL || state == S_DIV) ? cnt + 6'd1 : '0;
      if (launch) begin
        op <= mdu_op_e'(op_i);
        a <= src_a_i;
        b <= src_b_i;
        rem <= '0;
        quo <= mag(op_i == MDU_DIV && src_a_i[31], src_a_i);
      end
      if (state == S_DIV) begin
        rem <= rem_n;
        quo <= quo_n;
      end
      if (state_n == S_DONE && state != S_DONE) begin
        {hi_o, lo_o} <= res_n;
        div_zero_o <= dz_n;
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for the multiply/divide sequencer against an arithmetic model
module tb_mdu_ctrl;
  logic clk = 0, rst = 1, start_i = 0, flush_i = 0, ex_hold_i = 0;
  logic [1:0] op_i = 0;
  logic [31:0] src_a_i = 0, src_b_i = 0;
  logic stall_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;
  int checks = 0, fails = 0;
  logic [64:0] sbq[$];
  logic [64:0] last = '0;
  logic done_prev = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .flush_i(flush_i), .ex_hold_i(ex_hold_i), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
  );

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {div_zero, hi, lo} expected after the operation completes
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic dz);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    if (!op[1]) return {dz, op[0] ? ua * ub : 64'(sa * sb)};
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (op[0]) return {1'b0, a % b, a / b};
    return {1'b0, 32'(sa % sb), 32'(sa / sb)};
  endfunction

  always @(negedge clk) begin
    if (done_o && !done_prev) begin
      if (sbq.size() == 0) chk("unexpected_done", 68'(done_o), 68'd0);
      else chk("result", 68'({div_zero_o, hi_o, lo_o}), 68'(sbq.pop_front()));
    end
    done_prev = done_o;
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold, input int flush_at);
    logic [64:0] exp;
    int stalls = 0, cyc = 0, lat;
    exp = model(op, a, b, last[64]);
    lat = (op[1] && b == 0) ? 1 : op[1] ? 34 : 3;
    if (flush_at < 0) sbq.push_back(exp);
    @(posedge clk); #1;
    start_i = 1; op_i = op; src_a_i = a; src_b_i = b; ex_hold_i = hold > 0;
    forever begin
      if (cyc == flush_at) flush_i = 1;
      @(negedge clk);
      if (flush_i) begin
        chk("flush_stall", 68'(stall_o), 68'd0);
        break;
      end
      if (done_o) break;
      stalls += int'(stall_o);
      if (++cyc > 100) begin
        chk("timeout", 68'(done_o), 68'd1);
        break;
      end
      @(posedge clk); #1;
    end
    if (flush_i) begin
      @(posedge clk); #1;
      flush_i = 0; start_i = 0; ex_hold_i = 0;
      repeat (3) begin
        @(negedge clk);
        chk("flush_keep", 68'({done_o, div_zero_o, hi_o, lo_o}), 68'({1'b0, last}));
      end
      return;
    end
    chk("latency", 68'(stalls), 68'(lat));
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold", 68'({done_o, stall_o, div_zero_o, hi_o, lo_o}), 68'({2'b10, exp}));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      ex_hold_i = 0;
      @(negedge clk);
      chk("release", 68'({done_o, stall_o, div_zero_o, hi_o, lo_o}), 68'({2'b10, exp}));
    end
    @(posedge clk); #1;
    start_i = 0;
    last = exp;
    @(negedge clk);
    chk("idle_after", 68'({done_o, stall_o}), 68'd0);
  endtask

  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    int lat, fa;
    #1 chk("reset_state", 68'({done_o, stall_o, div_zero_o, hi_o, lo_o}), 68'd0);
    @(negedge clk); rst = 0;
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, -1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, -1);
    @(posedge clk); #1;
    start_i = 1; op_i = 2'b11; src_a_i = 32'd1000; src_b_i = 32'd3;
    repeat (5) @(posedge clk);
    #2 start_i = 0; rst = 1;
    #1 chk("async_rst", 68'({done_o, stall_o, div_zero_o, hi_o, lo_o}), 68'd0);
    @(negedge clk); rst = 0; last = '0;
    do_op(2'b11, 32'd100, 32'd7, 0, -1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, -1);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, -1);
    do_op(2'b10, 32'd5, 32'd0, 0, -1);
    do_op(2'b00, 32'd6, 32'd6, 0, -1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
    do_op(2'b11, 32'd5, 32'd0, 0, -1);
    do_op(2'b11, 32'd9, 32'd3, 0, -1);
    do_op(2'b11, 32'h1234_5678, 32'd77, 0, 10);
    do_op(2'b00, 32'd3, 32'd4, 0, 0);
    do_op(2'b01, 32'd3, 32'd4, 0, 1);
    do_op(2'b00, 32'd123, 32'hFFFF_FF00, 4, -1);
    do_op(2'b00, 32'd11, 32'd13, 0, -1);
    do_op(2'b11, 32'hFFFF_FFFF, 32'd10, 0, -1);
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      lat = (op[1] && b == 0) ? 1 : op[1] ? 34 : 3;
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      do_op(op, a, b, int'($urandom_range(0, 3)), fa);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 68'(sbq.size()), 68'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
